dest_arb_mux: RTL and testbench
===============================

# dest_arb_mux

Parametrised N-to-1 destination multiplexer with pop handshake toward the per-channel input FIFOs. It is the next generation of the 2-to-1 fixed-priority destination mux. Each cycle it selects one non-empty channel, pops it, and presents the word on a registered output. Selection is fixed-priority or round-robin, chosen at runtime, and the block stalls on downstream backpressure. It sits between the channel FIFOs and the destination FIFO in the routing path.

## Interface
- NUM_CH, 4: number of input channels, 2..16.
- DATA_W, 10: data word width.
- CH_W, $clog2(NUM_CH): channel-index width (derived).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed priority (channel 0 highest), 1 = round-robin.
- in_empty  in  NUM_CH  per-channel FIFO empty flag.
- in_data  in  NUM_CH*DATA_W  show-ahead FIFO heads; channel i at bits [i*DATA_W +: DATA_W].
- out_full  in  1  downstream full/almost-full; 1 blocks all pops.
- pop  out  NUM_CH  combinational one-hot (or zero) pop to the channel FIFOs.
- out_valid  out  1  registered; out_data/out_ch are meaningful.
- out_data  out  DATA_W  registered selected word.
- out_ch  out  CH_W  registered index of the source channel.

## Operation
- Request vector: req = ~in_empty.
- No pop is issued when any of the following holds: reset = 1, out_full = 1, or req = 0.
- Fixed mode: grant goes to the lowest-index requesting channel.
- Round-robin mode:
  - Search starts at (last_grant + 1) mod NUM_CH and wraps; the first requester wins.
  - last_grant updates only in a cycle where a pop is issued.
- last_grant is kept in both modes and is updated by fixed-mode grants too, so switching modes never needs re-initialisation.
- A mode change takes effect in the same cycle it is sampled.
- pop[g] = 1 for the granted channel g only. pop is never multi-hot.
- On a pop cycle, the next edge registers:
  - out_valid = 1
  - out_data = in_data[g]
  - out_ch = g
- On a non-pop cycle, the next edge sets out_valid = 0. out_data and out_ch hold their last values.
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, last_grant = NUM_CH-1 (so channel 0 wins first in RR), pop = 0 while reset = 1.
- No data is lost or duplicated: every pop produces exactly one out_valid beat carrying that word.

## Timing
- pop is combinational from in_empty, out_full, mode, last_grant and reset in the same cycle. There is no register on the pop path.
- Latency is 1 cycle from the pop cycle to out_valid.
- Throughput is 1 word per cycle while req ≠ 0 and out_full = 0.
- out_full is sampled in the cycle the pop would occur. The word already registered in out_data is not retracted; downstream must absorb one in-flight beat. out_full is therefore an almost-full flag with margin ≥1.
- Boundary conditions:
  - Only one channel requests: it is granted every cycle in both modes.
  - last_grant = NUM_CH-1: the RR search wraps to channel 0.
  - Reset asserted mid-stream: pop is forced to 0 that cycle and all registers take their reset values at that edge. The FIFO entry under consideration is not popped.
  - A channel's empty flag rises in the same cycle it would have been granted: it is not requested and the next requester wins.

## Structure
- Shared include dest_arb_pkg.vh holds:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1
  - the default NUM_CH / DATA_W constants used by the routing top level.
- Sub-module rr_pick:
  - combinational; inputs are req[NUM_CH] and a start index.
  - outputs a one-hot grant and its binary index.
  - Fixed mode reuses it with start = 0.
- The top module contains the last_grant register, the output register stage, the data mux (indexed part-select on in_data) and the pop gating.

## Test plan
- Reset: hold reset = 1 for 3 cycles with all channels non-empty -> pop = 0000, out_valid = 0, out_data = 0, out_ch = 0 throughout.
- Fixed priority: in_empty = 0000, mode = 0, heads 0x001/0x002/0x003/0x004 -> pop = 0001 every cycle; out_valid = 1, out_ch = 0, out_data = 0x001 from the cycle after the first pop.
- Round-robin: in_empty = 0000, mode = 1 after reset -> pop sequence 0001, 0010, 0100, 1000, 0001; out_ch sequence 0, 1, 2, 3, 0, each delayed 1 cycle.
- RR skip and wrap: in_empty = 0101 (channels 1 and 3 requesting), mode = 1 -> grants alternate 1, 3, 1, 3; channels 0 and 2 are never popped.
- Backpressure: stream in RR, raise out_full for 2 cycles -> pop = 0000 and out_valid = 0 for those 2 beats (+1 latency). On release, arbitration resumes from the channel after the last one popped; no word is dropped or repeated, checked by scoreboard against FIFO contents.
- Mid-stream reset and mode switch: switch mode 1 -> 0 while last_grant = 2 -> the next grant is the lowest requester. Assert reset for 1 cycle -> last_grant returns to 3, and the first RR grant after reset is channel 0.

Source files
------------

// File: rtl/dest_arb_mux_pkg.sv
// Shared constants for the destination arbiter mux.
// Mode encodings and the routing top level's default sizes.
package dest_arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 10;

endpackage

// File: rtl/dest_arb_mux_if.sv
// Channel-FIFO side and destination side of the arbiter mux.
// slave is the mux itself; master is whoever drives the FIFOs.
interface dest_arb_mux_if #(
  parameter int NUM_CH = dest_arb_mux_pkg::DEF_NUM_CH,
  parameter int DATA_W = dest_arb_mux_pkg::DEF_DATA_W
);

  localparam int CH_W = $clog2(NUM_CH);

  logic                     mode;
  logic [NUM_CH-1:0]        in_empty;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_full;
  logic [NUM_CH-1:0]        pop;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;

  modport slave (
    input  mode,
    input  in_empty,
    input  in_data,
    input  out_full,
    output pop,
    output out_valid,
    output out_data,
    output out_ch
  );

  modport master (
    output mode,
    output in_empty,
    output in_data,
    output out_full,
    input  pop,
    input  out_valid,
    input  out_data,
    input  out_ch
  );

endinterface

// File: rtl/dest_arb_mux_rr_pick.sv
// Combinational rotating picker: first requester at or after start.
// Fixed priority is the same search with start = 0.
module dest_arb_mux_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_start,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);

  always_comb begin
    int j;
    logic [CH_W-1:0] w_j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    w_j   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(i_start) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      w_j = CH_W'(j);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/dest_arb_mux.sv
// N-to-1 destination mux: pops one channel FIFO per cycle and
// registers the word; fixed or round-robin pick chosen at runtime.
module dest_arb_mux
  import dest_arb_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic          clk,
  input  logic          reset,
  dest_arb_mux_if.slave bus
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]   r_last;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_ch;

  logic [NUM_CH-1:0] w_req;
  logic [CH_W-1:0]   w_rr_start;
  logic [CH_W-1:0]   w_start;
  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_fire;
  logic [DATA_W-1:0] w_word;

  assign w_req      = ~bus.in_empty;
  assign w_rr_start = (r_last == LAST_CH) ? '0 : r_last + 1'b1;
  assign w_start    = (bus.mode == MODE_RR) ? w_rr_start : '0;

  dest_arb_mux_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .i_req   (w_req),
    .i_start (w_start),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // reset and out_full gate the pop the same cycle, no pipeline
  assign w_fire = w_any && !bus.out_full && !reset;
  assign w_word = bus.in_data[int'(w_idx)*DATA_W +: DATA_W];

  assign bus.pop       = w_fire ? w_gnt : '0;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= LAST_CH;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
    end else begin
      r_valid <= w_fire;
      if (w_fire) begin
        r_last <= w_idx;
        r_data <= w_word;
        r_ch   <= w_idx;
      end
    end
  end

endmodule

// File: tb/tb_dest_arb_mux.sv
// Directed bench for dest_arb_mux: reset, fixed, RR, skip/wrap,
// backpressure with a FIFO scoreboard, mode switch and mid-run reset.
module tb_dest_arb_mux;
  import dest_arb_mux_pkg::*;

  localparam int N = 4;
  localparam int W = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_arb_mux_if #(.NUM_CH(N), .DATA_W(W)) bus ();

  dest_arb_mux #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  bit fifo_en = 1'b0;
  int rd [N];
  int len [N];

  function automatic logic [W-1:0] mk(int ch, int k);
    return W'((ch << 8) | (k + 1));
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      bus.in_empty[i] = (rd[i] >= len[i]);
      bus.in_data[i*W +: W] = mk(i, rd[i]);
    end
  endtask

  task automatic tick();
    logic [N-1:0] p;
    p = bus.pop;
    @(posedge clk);
    #1;
    if (fifo_en) begin
      for (int i = 0; i < N; i++)
        if (p[i]) rd[i]++;
      refresh();
    end
  endtask

  task automatic set_heads();
    bus.in_data = {10'h004, 10'h003, 10'h002, 10'h001};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mode = MODE_RR;
    bus.in_empty = '0;
    bus.out_full = 1'b0;
    set_heads();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.pop !== 4'b0000) begin
        errors++;
        $display("FAIL reset_pop c=%0d got=%b exp=0000", c, bus.pop);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid c=%0d got=%b exp=0", c, bus.out_valid);
      end
      checks++;
      if (bus.out_data !== 10'h000) begin
        errors++;
        $display("FAIL reset_data c=%0d got=%h exp=000", c, bus.out_data);
      end
      checks++;
      if (bus.out_ch !== 2'd0) begin
        errors++;
        $display("FAIL reset_ch c=%0d got=%0d exp=0", c, bus.out_ch);
      end
    end
  endtask

  task automatic test_fixed();
    bus.mode = MODE_FIXED;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL fixed_pop0 got=%b exp=0001", bus.pop);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.pop !== 4'b0001) begin
        errors++;
        $display("FAIL fixed_pop c=%0d got=%b exp=0001", c, bus.pop);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0) begin
        errors++;
        $display("FAIL fixed_out c=%0d got=%b/%0d exp=1/0",
                 c, bus.out_valid, bus.out_ch);
      end
      checks++;
      if (bus.out_data !== 10'h001) begin
        errors++;
        $display("FAIL fixed_data c=%0d got=%h exp=001", c, bus.out_data);
      end
    end
  endtask

  task automatic test_rr();
    logic [3:0] ep [5];
    logic [1:0] ech [5];
    ep  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ech = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mode = MODE_RR;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.pop !== ep[c]) begin
        errors++;
        $display("FAIL rr_pop c=%0d got=%b exp=%b", c, bus.pop, ep[c]);
      end
      if (c > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== ech[c-1]) begin
          errors++;
          $display("FAIL rr_ch c=%0d got=%b/%0d exp=1/%0d",
                   c, bus.out_valid, bus.out_ch, ech[c-1]);
        end
        checks++;
        if (bus.out_data !== 10'(ech[c-1]) + 10'd1) begin
          errors++;
          $display("FAIL rr_data c=%0d got=%h exp=%h",
                   c, bus.out_data, 10'(ech[c-1]) + 10'd1);
        end
      end
      tick();
    end
    checks++;
    if (bus.out_ch !== 2'd0) begin
      errors++;
      $display("FAIL rr_last_ch got=%0d exp=0", bus.out_ch);
    end
  endtask

  task automatic test_rr_skip();
    logic [3:0] ep [4];
    ep = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mode = MODE_RR;
    bus.in_empty = 4'b0101;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.pop !== ep[c]) begin
        errors++;
        $display("FAIL skip_pop c=%0d got=%b exp=%b", c, bus.pop, ep[c]);
      end
      tick();
    end
    bus.in_empty = 4'b1011;
    for (int c = 0; c < 4; c++) begin
      bus.mode = c[0];
      #1;
      checks++;
      if (bus.pop !== 4'b0100) begin
        errors++;
        $display("FAIL single_pop c=%0d got=%b exp=0100", c, bus.pop);
      end
      tick();
    end
    bus.in_empty = 4'b0000;
  endtask

  task automatic test_backpressure();
    int exp_idx [N];
    int beats;
    beats = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mode = MODE_RR;
    bus.out_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      len[i] = 5;
      rd[i] = 0;
      exp_idx[i] = 0;
    end
    fifo_en = 1'b1;
    refresh();
    #1;
    for (int c = 0; c < 40; c++) begin
      bus.out_full = (c == 3 || c == 4);
      #1;
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.out_data !== mk(int'(bus.out_ch), exp_idx[bus.out_ch])) begin
          errors++;
          $display("FAIL bp_score c=%0d ch=%0d got=%h exp=%h", c, bus.out_ch,
                   bus.out_data, mk(int'(bus.out_ch), exp_idx[bus.out_ch]));
        end
        exp_idx[bus.out_ch]++;
        beats++;
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (bus.pop !== 4'b0000) begin
          errors++;
          $display("FAIL bp_stall_pop c=%0d got=%b exp=0000", c, bus.pop);
        end
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall_valid c=%0d got=%b exp=0", c, bus.out_valid);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.out_data !== mk(2, 0)) begin
          errors++;
          $display("FAIL bp_hold got=%h exp=%h", bus.out_data, mk(2, 0));
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.pop !== 4'b1000) begin
          errors++;
          $display("FAIL bp_resume got=%b exp=1000", bus.pop);
        end
      end
      tick();
    end
    fifo_en = 1'b0;
    bus.out_full = 1'b0;
    checks++;
    if (beats !== 20) begin
      errors++;
      $display("FAIL bp_beats got=%0d exp=20", beats);
    end
    checks++;
    if (rd[0] + rd[1] + rd[2] + rd[3] !== 20) begin
      errors++;
      $display("FAIL bp_pops got=%0d exp=20", rd[0] + rd[1] + rd[2] + rd[3]);
    end
  endtask

  task automatic test_mode_switch();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mode = MODE_RR;
    bus.in_empty = 4'b0000;
    set_heads();
    tick();
    tick();
    checks++;
    if (bus.pop !== 4'b0100) begin
      errors++;
      $display("FAIL ms_pre got=%b exp=0100", bus.pop);
    end
    tick();
    bus.mode = MODE_FIXED;
    #1;
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL ms_fixed got=%b exp=0001", bus.pop);
    end
    bus.in_empty = 4'b0001;
    #1;
    checks++;
    if (bus.pop !== 4'b0010) begin
      errors++;
      $display("FAIL ms_fixed_low got=%b exp=0010", bus.pop);
    end
    tick();
    checks++;
    if (bus.out_ch !== 2'd1 || bus.out_data !== 10'h002) begin
      errors++;
      $display("FAIL ms_out got=%0d/%h exp=1/002", bus.out_ch, bus.out_data);
    end
    bus.mode = MODE_RR;
    bus.in_empty = 4'b0000;
    #1;
    checks++;
    if (bus.pop !== 4'b0100) begin
      errors++;
      $display("FAIL ms_rr got=%b exp=0100", bus.pop);
    end
    bus.in_empty = 4'b0100;
    #1;
    checks++;
    if (bus.pop !== 4'b1000) begin
      errors++;
      $display("FAIL ms_empty_rise got=%b exp=1000", bus.pop);
    end
    tick();
    bus.in_empty = 4'b0000;
    #1;
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL ms_wrap got=%b exp=0001", bus.pop);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pop !== 4'b0000) begin
      errors++;
      $display("FAIL ms_rst_pop got=%b exp=0000", bus.pop);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_ch !== 2'd0 || bus.out_data !== 10'h000) begin
      errors++;
      $display("FAIL ms_rst_regs got=%b/%0d/%h exp=0/0/000",
               bus.out_valid, bus.out_ch, bus.out_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL ms_rst_first got=%b exp=0001", bus.pop);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0) begin
      errors++;
      $display("FAIL ms_post got=%b/%0d exp=1/0", bus.out_valid, bus.out_ch);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      len[i] = 0;
    end
    test_reset();
    test_fixed();
    test_rr();
    test_rr_skip();
    test_backpressure();
    test_mode_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
